button_stepper: RTL and testbench
=================================

Name: button_stepper

Overview:
- Parametrised successor of the front-panel phase button block: two push-buttons (up/down) step a bounded register value.
- Provides per-button synchronisation, counter-based debouncing on a divided tick, configurable step/range, saturate or wrap mode, and status flags.
- Sits between board button pins and any tuning register (phase increment, gain, threshold).

Parameters:
- WIDTH, 8, width of value output
- DEFAULT, 1, reset value of value; MIN <= DEFAULT <= MAX
- MIN, 0, lowest legal value
- MAX, 255, highest legal value; MAX - MIN >= STEP
- STEP, 1, increment/decrement per press event
- TICK_DIV, 10000, clk cycles per debounce tick; >= 2
- DEB_TICKS, 4, consecutive disagreeing ticks needed to accept a new level; >= 1
- WRAP, 0, 0 = saturate at MIN/MAX; 1 = wrap MAX->MIN and MIN->MAX

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- btn_up  in  1  raw up button, active-high when pressed, asynchronous
- btn_dn  in  1  raw down button, active-high when pressed, asynchronous
- value  out  WIDTH  current stepped value
- at_min  out  1  high while value == MIN
- at_max  out  1  high while value == MAX
- changed  out  1  one-cycle pulse on the cycle value updates

Behaviour:
- Reset, asynchronous on reset low: value = DEFAULT; changed = 0; at_min/at_max are combinational from value; tick counter = 0; sync flops = 0; debounce counters = 0; stable levels = 0 (released).
- Tick: counter runs 0..TICK_DIV-1 and wraps. tick is a 1-cycle pulse when counter == TICK_DIV-1.
- Sync: each button passes through a 2-flop synchroniser every clk. It is not gated by tick.
- Debounce per button, evaluated only on tick:
  - synced level == stable: clear the count.
  - otherwise increment the count; when the count reaches DEB_TICKS, stable takes the synced level and the count clears.
  - Glitches shorter than DEB_TICKS ticks are ignored.
- Press event: a 1-cycle pulse on the clk after stable goes 0->1. Release produces no event.
- Update, registered on the cycle following the event; changed pulses on that same cycle:
  - up only: value + STEP. If the result would exceed MAX: saturate -> MAX (changed = 0 if already MAX); wrap -> MIN.
  - dn only: value - STEP. If the result would go below MIN: saturate -> MIN (changed = 0 if already MIN); wrap -> MAX.
  - up and dn events in the same cycle: no change, changed = 0.
- Arithmetic: internal sum/difference computed at WIDTH+1 bits, so there is no silent modular overflow before comparison.
- Latency: raw edge -> value change = 2 clk (sync) + DEB_TICKS ticks + 1 tick quantisation + 2 clk.
- Held button: exactly one event per press in the base build.
- Reset mid-debounce or mid-hold: all state returns to its reset values. A button still held when reset releases generates one event after debouncing, because stable restarts at 0.

Optional Feature:
- Macro BUTTON_STEPPER_AUTOREPEAT_EN.
- Defined: adds parameters REPEAT_DELAY (default 125 ticks) and REPEAT_RATE (default 25 ticks).
  - While a stable level stays 1, a repeat counter advances on tick.
  - After REPEAT_DELAY ticks the block issues an extra press event, then one every REPEAT_RATE ticks until release.
  - Release or reset clears the repeat counter.
  - If both buttons are held, repeats follow the same simultaneity rule (no change when events coincide).
- Undefined: no repeat logic; one event per press.

Decomposition:
- Shared package button_pkg holds:
  - a localparam helper function for the tick-counter width, clog2(TICK_DIV)
  - the debounce-count width, clog2(DEB_TICKS+1)
  - the mode constants MODE_SATURATE = 0 and MODE_WRAP = 1
- Sub-module btn_debounce, instantiated twice, contains the synchroniser, debounce counter, stable level, press pulse and the optional repeat counter.
- The top level contains the tick divider, update arithmetic and flags.

Test Plan:
- Reset, with TICK_DIV=4, DEB_TICKS=2, DEFAULT=1: value=1, at_min=0, at_max=0, changed=0; a clean 100-cycle btn_up press -> value=2, single changed pulse.
- Bounce: 3 toggles of btn_up each 1 tick long, then steady high 40 cycles -> exactly one increment.
- Saturation, WRAP=0, MIN=0, MAX=3, DEFAULT=3: btn_up press -> value stays 3, changed=0, at_max=1; btn_dn press -> value=2.
- Wrap, WRAP=1, MIN=2, MAX=5, STEP=1, DEFAULT=5: btn_up -> value=2; then btn_dn -> value=5.
- Simultaneous: btn_up and btn_dn asserted the same clk for 100 cycles -> value unchanged, changed never pulses.
- Autorepeat build, REPEAT_DELAY=3, REPEAT_RATE=2: hold btn_up for 20 ticks from value 0 -> value 1 at press, then +1 after 3 ticks and every 2 ticks after; reset asserted mid-hold -> value=DEFAULT immediately.

Source files
------------

// File: rtl/button_pkg.sv
// Shared constants and width helper for the button stepper slice.
// Optional autorepeat is enabled with BUTTON_STEPPER_AUTOREPEAT_EN.
package button_pkg;

  localparam int MODE_SATURATE = 0;
  localparam int MODE_WRAP     = 1;

  // Bits needed to hold a count of 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, tick-based debounce, press pulse and,
// with BUTTON_STEPPER_AUTOREPEAT_EN defined, a hold-to-repeat counter.
module btn_debounce
  import button_pkg::*;
#(
  parameter int DEB_TICKS = 4
`ifdef BUTTON_STEPPER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 125,
  parameter int REPEAT_RATE  = 25
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  output logic press
);

  localparam int DW = cnt_width(DEB_TICKS + 1);

  logic          sync1_q, sync2_q;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          stable_prev_q;
  logic          press_q, press_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (tick) begin
      if (sync2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == DW'(DEB_TICKS - 1)) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

`ifdef BUTTON_STEPPER_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = cnt_width(REP_MAX + 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_phase_q, rep_phase_d;
  logic          rep_q, rep_d;

  // Phase 0 waits out the initial delay, phase 1 then fires at the repeat rate.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    rep_d       = 1'b0;
    if (!stable_q) begin
      rep_cnt_d   = '0;
      rep_phase_d = 1'b0;
    end else if (tick) begin
      if (rep_cnt_q == (rep_phase_q ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1))) begin
        rep_d       = 1'b1;
        rep_cnt_d   = '0;
        rep_phase_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
      rep_q       <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
      rep_q       <= rep_d;
    end
  end

  assign press_d = (stable_q & ~stable_prev_q) | rep_q;
`else
  assign press_d = stable_q & ~stable_prev_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      press_q       <= 1'b0;
    end else begin
      sync1_q       <= btn;
      sync2_q       <= sync1_q;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      press_q       <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/button_stepper.sv
// Two debounced push-buttons step a bounded register (saturate or wrap).
// Define BUTTON_STEPPER_AUTOREPEAT_EN to add hold-to-repeat stepping.
module button_stepper
  import button_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEFAULT   = 1,
  parameter int MIN       = 0,
  parameter int MAX       = 255,
  parameter int STEP      = 1,
  parameter int TICK_DIV  = 10000,
  parameter int DEB_TICKS = 4,
  parameter int WRAP      = 0
`ifdef BUTTON_STEPPER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 125,
  parameter int REPEAT_RATE  = 25
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_dn,
  output logic [WIDTH-1:0] value,
  output logic             at_min,
  output logic             at_max,
  output logic             changed
);

  localparam int TW = cnt_width(TICK_DIV);

  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] DEF_V  = WIDTH'(DEFAULT);
  localparam logic [WIDTH:0]   MIN_X  = (WIDTH + 1)'(MIN);
  localparam logic [WIDTH:0]   MAX_X  = (WIDTH + 1)'(MAX);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(STEP);

  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic             up_ev, dn_ev;
  logic [WIDTH-1:0] value_q, value_d;
  logic             changed_q, changed_d;
  logic [WIDTH:0]   sum_x, diff_x;
  logic             below_min;

  assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

`ifdef BUTTON_STEPPER_AUTOREPEAT_EN
  btn_debounce #(
    .DEB_TICKS   (DEB_TICKS),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_up (.clk(clk), .reset(reset), .tick(tick), .btn(btn_up), .press(up_ev));

  btn_debounce #(
    .DEB_TICKS   (DEB_TICKS),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_dn (.clk(clk), .reset(reset), .tick(tick), .btn(btn_dn), .press(dn_ev));
`else
  btn_debounce #(
    .DEB_TICKS(DEB_TICKS)
  ) u_up (.clk(clk), .reset(reset), .tick(tick), .btn(btn_up), .press(up_ev));

  btn_debounce #(
    .DEB_TICKS(DEB_TICKS)
  ) u_dn (.clk(clk), .reset(reset), .tick(tick), .btn(btn_dn), .press(dn_ev));
`endif

  // One extra bit keeps overflow and underflow visible before range checks.
  assign sum_x     = {1'b0, value_q} + STEP_X;
  assign diff_x    = {1'b0, value_q} - STEP_X;
  assign below_min = diff_x[WIDTH] || (diff_x < MIN_X);

  always_comb begin
    value_d   = value_q;
    changed_d = 1'b0;
    if (up_ev && !dn_ev) begin
      if (sum_x > MAX_X) begin
        if (WRAP == MODE_WRAP) begin
          value_d   = MIN_V;
          changed_d = 1'b1;
        end else if (value_q != MAX_V) begin
          value_d   = MAX_V;
          changed_d = 1'b1;
        end
      end else begin
        value_d   = sum_x[WIDTH-1:0];
        changed_d = 1'b1;
      end
    end else if (dn_ev && !up_ev) begin
      if (below_min) begin
        if (WRAP == MODE_WRAP) begin
          value_d   = MAX_V;
          changed_d = 1'b1;
        end else if (value_q != MIN_V) begin
          value_d   = MIN_V;
          changed_d = 1'b1;
        end
      end else begin
        value_d   = diff_x[WIDTH-1:0];
        changed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      value_q    <= DEF_V;
      changed_q  <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      value_q    <= value_d;
      changed_q  <= changed_d;
    end
  end

  assign value   = value_q;
  assign at_min  = (value_q == MIN_V);
  assign at_max  = (value_q == MAX_V);
  assign changed = changed_q;

endmodule

// File: tb/tb_button_stepper.sv
// Scoreboard bench for button_stepper: plain, saturating and wrapping instances,
// plus an autorepeat instance when BUTTON_STEPPER_AUTOREPEAT_EN is defined.
module tb_button_stepper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] btns = '0;

  logic [7:0] val_a, val_b, val_c;
  logic       amin_a, amax_a, chg_a;
  logic       amin_b, amax_b, chg_b;
  logic       amin_c, amax_c, chg_c;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int q_a[$];
  int q_b[$];
  int q_c[$];

  always #5 clk = ~clk;

  button_stepper #(.WIDTH(8), .DEFAULT(1), .MIN(0), .MAX(255), .STEP(1),
                   .TICK_DIV(4), .DEB_TICKS(2), .WRAP(0))
    dut_a (.clk(clk), .reset(rst_n), .btn_up(btns[0]), .btn_dn(btns[1]),
           .value(val_a), .at_min(amin_a), .at_max(amax_a), .changed(chg_a));

  button_stepper #(.WIDTH(8), .DEFAULT(3), .MIN(0), .MAX(3), .STEP(1),
                   .TICK_DIV(4), .DEB_TICKS(2), .WRAP(0))
    dut_b (.clk(clk), .reset(rst_n), .btn_up(btns[2]), .btn_dn(btns[3]),
           .value(val_b), .at_min(amin_b), .at_max(amax_b), .changed(chg_b));

  button_stepper #(.WIDTH(8), .DEFAULT(5), .MIN(2), .MAX(5), .STEP(1),
                   .TICK_DIV(4), .DEB_TICKS(2), .WRAP(1))
    dut_c (.clk(clk), .reset(rst_n), .btn_up(btns[4]), .btn_dn(btns[5]),
           .value(val_c), .at_min(amin_c), .at_max(amax_c), .changed(chg_c));

`ifdef BUTTON_STEPPER_AUTOREPEAT_EN
  logic       rst_d_n = 1'b0;
  logic       d_up = 1'b0;
  logic [7:0] val_d;
  logic       amin_d, amax_d, chg_d;
  int         q_d[$];
  int         g_d[$];
  int         last_d = 0;

  button_stepper #(.WIDTH(8), .DEFAULT(0), .MIN(0), .MAX(255), .STEP(1),
                   .TICK_DIV(4), .DEB_TICKS(2), .WRAP(0),
                   .REPEAT_DELAY(3), .REPEAT_RATE(2))
    dut_d (.clk(clk), .reset(rst_d_n), .btn_up(d_up), .btn_dn(1'b0),
           .value(val_d), .at_min(amin_d), .at_max(amax_d), .changed(chg_d));
`endif

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] mask, input int hi);
    @(posedge clk); #1 btns = mask;
    repeat (hi) @(posedge clk);
    #1 btns = '0;
    repeat (40) @(posedge clk);
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 200 && (q_a.size() + q_b.size() + q_c.size()) != 0; i++)
      @(negedge clk);
    check("a_pending_events", q_a.size(), 0);
    check("b_pending_events", q_b.size(), 0);
    check("c_pending_events", q_c.size(), 0);
  endtask

  initial begin
    int e;
    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (chg_a) begin
          if (q_a.size() == 0) check("a_spurious_changed", 1, 0);
          else begin
            e = q_a.pop_front();
            check("a_value", val_a, e);
            check("a_at_min", amin_a, int'(e == 0));
            check("a_at_max", amax_a, int'(e == 255));
          end
        end
        if (chg_b) begin
          if (q_b.size() == 0) check("b_spurious_changed", 1, 0);
          else begin
            e = q_b.pop_front();
            check("b_value", val_b, e);
            check("b_at_min", amin_b, int'(e == 0));
            check("b_at_max", amax_b, int'(e == 3));
          end
        end
        if (chg_c) begin
          if (q_c.size() == 0) check("c_spurious_changed", 1, 0);
          else begin
            e = q_c.pop_front();
            check("c_value", val_c, e);
            check("c_at_min", amin_c, int'(e == 2));
            check("c_at_max", amax_c, int'(e == 5));
          end
        end
`ifdef BUTTON_STEPPER_AUTOREPEAT_EN
        if (chg_d) begin
          if (q_d.size() == 0) check("d_spurious_changed", 1, 0);
          else begin
            e = q_d.pop_front();
            check("d_value", val_d, e);
            e = g_d.pop_front();
            if (e != 0) check("d_event_gap", cyc - last_d, e);
          end
          last_d = cyc;
        end
`endif
      end
    join_none

    repeat (3) @(negedge clk);
    check("a_reset_value", val_a, 1);
    check("a_reset_at_min", amin_a, 0);
    check("a_reset_at_max", amax_a, 0);
    check("a_reset_changed", chg_a, 0);
    check("b_reset_value", val_b, 3);
    check("b_reset_at_max", amax_b, 1);
    check("c_reset_value", val_c, 5);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // Clean up press: A steps, B sits at MAX, C wraps to MIN.
    q_a.push_back(2);
    q_c.push_back(2);
    applyStimulus(6'b010101, 100);
    checkOutput();
    check("b_saturated_value", val_b, 3);
    check("b_saturated_at_max", amax_b, 1);

    // Three one-tick glitches followed by a steady press yield one step.
    q_a.push_back(3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 btns = 6'b000001;
      repeat (4) @(posedge clk);
      #1 btns = '0;
      repeat (4) @(posedge clk);
    end
    applyStimulus(6'b000001, 40);
    checkOutput();

    // Down presses: B steps down, C wraps MIN -> MAX.
    q_b.push_back(2);
    q_c.push_back(5);
    applyStimulus(6'b101000, 40);
    q_b.push_back(1);
    applyStimulus(6'b001000, 40);
    q_b.push_back(0);
    applyStimulus(6'b001000, 40);
    applyStimulus(6'b001000, 40);
    checkOutput();
    check("b_floor_value", val_b, 0);
    check("b_floor_at_min", amin_b, 1);

    // Simultaneous up and down presses cancel out.
    applyStimulus(6'b000011, 100);
    checkOutput();
    check("a_simultaneous_value", val_a, 3);

    q_a.push_back(2);
    applyStimulus(6'b000010, 40);
    checkOutput();

`ifdef BUTTON_STEPPER_AUTOREPEAT_EN
    // Press at t0, repeats 3 ticks (12 clk) then every 2 ticks (8 clk) later.
    q_d.push_back(1); g_d.push_back(0);
    q_d.push_back(2); g_d.push_back(12);
    q_d.push_back(3); g_d.push_back(8);
    q_d.push_back(4); g_d.push_back(8);
    @(posedge clk); #1 rst_d_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 d_up = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        seen = chg_d;
      end
      check("d_first_event_seen", int'(seen), 1);
    end
    repeat (30) @(negedge clk);
    rst_d_n = 1'b0;
    #1;
    check("d_reset_value", val_d, 0);
    check("d_reset_changed", chg_d, 0);
    check("d_pending_events", q_d.size(), 0);
    d_up = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_d_n = 1'b1;
    repeat (40) @(posedge clk);
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
